// File: rtl/sniffer_input_fifo_if.sv
// Ingress Avalon-ST and egress pop bundle for the sniffer input FIFO.
// master: packet source / sniffer controller; slave: the FIFO itself.
interface sniffer_input_fifo_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic [1:0]  in_empty;
  logic        in_error;
  logic        in_ready;
  logic        rdreq;
  logic        rdempty;
  logic [31:0] data_out;
  logic        sop;
  logic        eop;
  logic [1:0]  empty;
  logic        error;
  logic        valid;
  logic [15:0] drop_count;
  logic [15:0] pkt_count;

  modport master (
    output in_data, in_valid, in_sop, in_eop,
    output in_empty, in_error, rdreq,
    input  in_ready, rdempty, data_out, sop, eop,
    input  empty, error, valid, drop_count, pkt_count
  );

  modport slave (
    input  in_data, in_valid, in_sop, in_eop,
    input  in_empty, in_error, rdreq,
    output in_ready, rdempty, data_out, sop, eop,
    output empty, error, valid, drop_count, pkt_count
  );
endinterface

// File: rtl/sniffer_input_fifo.sv
// Packet-aware receive FIFO: sop/eop framing check on ingress,
// circular word buffer, registered one-word pop with counters.
// Ports: clk, n_rst (sync, active low), bus (sniffer_input_fifo_if.slave).
module sniffer_input_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic                  clk,
  input logic                  n_rst,
  sniffer_input_fifo_if.slave  bus
);
  // entry: {data, sop, eop, empty, error}
  localparam int ENT_W = 37;
  localparam logic [ADDR_W:0] L_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_IN_PKT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  logic [31:0] r_data_out;
  logic        r_sop;
  logic        r_eop;
  logic [1:0]  r_empty;
  logic        r_error;
  logic        r_valid;
  logic [15:0] r_drop_count;
  logic [15:0] r_pkt_count;

  logic             w_acc;
  logic             w_wr;
  logic             w_rd;
  logic             w_drop;
  logic             w_err_force;
  logic [ENT_W-1:0] w_wr_ent;
  logic [ENT_W-1:0] w_rd_ent;

  // Reset dominates so the source sees ready and the sink sees
  // empty for the whole time n_rst is low.
  assign bus.in_ready = (r_count != L_FULL) || !n_rst;
  assign bus.rdempty  = (r_count == '0) || !n_rst;

  assign w_acc = bus.in_valid && (r_count != L_FULL);
  assign w_rd  = bus.rdreq && (r_count != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_drop      = 1'b0;
    w_err_force = 1'b0;
    if (w_acc) begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_sop) begin
            w_wr        = 1'b1;
            w_state_nxt = bus.in_eop ? S_IDLE : S_IN_PKT;
          end else begin
            w_drop = 1'b1;
          end
        end
        S_IN_PKT: begin
          // sop inside a packet: previous packet lost its eop
          w_wr        = 1'b1;
          w_err_force = bus.in_sop;
          w_state_nxt = bus.in_eop ? S_IDLE : S_IN_PKT;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_wr_ent = {
    bus.in_data,
    bus.in_sop,
    bus.in_eop,
    bus.in_eop ? bus.in_empty : 2'b00,
    bus.in_error | w_err_force
  };

  assign w_rd_ent = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_wr_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_data_out   <= '0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_empty      <= '0;
      r_error      <= 1'b0;
      r_valid      <= 1'b0;
      r_drop_count <= '0;
      r_pkt_count  <= '0;
    end else begin
      r_valid <= w_rd;
      if (w_rd) begin
        r_data_out <= w_rd_ent[36:5];
        r_sop      <= w_rd_ent[4];
        r_eop      <= w_rd_ent[3];
        r_empty    <= w_rd_ent[2:1];
        r_error    <= w_rd_ent[0];
      end
      if (w_rd && w_rd_ent[3] && (r_pkt_count != 16'hFFFF)) begin
        r_pkt_count <= r_pkt_count + 1'b1;
      end
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.sop        = r_sop;
  assign bus.eop        = r_eop;
  assign bus.empty      = r_empty;
  assign bus.error      = r_error;
  assign bus.valid      = r_valid;
  assign bus.drop_count = r_drop_count;
  assign bus.pkt_count  = r_pkt_count;
endmodule

// File: tb/tb_sniffer_input_fifo.sv
// Scoreboard bench for sniffer_input_fifo: directed packets, full,
// drop, missing-eop, empty-pop, push/pop overlap and mid-packet reset.
module tb_sniffer_input_fifo;
  logic clk;
  logic n_rst;
  int   checks;
  int   failures;
  logic [36:0] sb[$];

  sniffer_input_fifo_if u_if ();

  sniffer_input_fifo #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // monitor: every valid pulse must match the oldest expected word
  always @(negedge clk) begin
    if (n_rst && u_if.valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual=%0h required=none",
                 u_if.data_out);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("pop_word",
            {27'd0, u_if.data_out, u_if.sop, u_if.eop,
             u_if.empty, u_if.error},
            {27'd0, e});
      end
    end
  end

  task automatic push(input logic [31:0] d, input logic s, input logic e,
                      input logic [1:0] emp, input logic st,
                      input logic er);
    bit acc;
    u_if.in_data  = d;
    u_if.in_sop   = s;
    u_if.in_eop   = e;
    u_if.in_empty = emp;
    u_if.in_error = 1'b0;
    u_if.in_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (u_if.in_ready) acc = 1;
    end
    if (!acc) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    if (st) sb.push_back({d, s, e, e ? emp : 2'b00, er});
  endtask

  task automatic pop(input logic ev);
    u_if.rdreq = 1'b1;
    @(posedge clk);
    #1;
    u_if.rdreq = 1'b0;
    chk("pop_valid", u_if.valid, ev);
  endtask

  initial begin
    logic [31:0] held;
    checks   = 0;
    failures = 0;
    n_rst         = 1'b0;
    u_if.in_data  = '0;
    u_if.in_valid = 1'b0;
    u_if.in_sop   = 1'b0;
    u_if.in_eop   = 1'b0;
    u_if.in_empty = '0;
    u_if.in_error = 1'b0;
    u_if.rdreq    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdempty", u_if.rdempty, 1);
    chk("rst_in_ready", u_if.in_ready, 1);
    chk("rst_outs",
        {u_if.data_out, u_if.sop, u_if.eop, u_if.empty,
         u_if.error, u_if.valid},
        0);
    chk("rst_counts", {u_if.drop_count, u_if.pkt_count}, 0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // 3-word packet
    push(32'hA0, 1, 0, 2'd0, 1, 0);
    chk("rdempty_after_wr", u_if.rdempty, 0);
    push(32'hA1, 0, 0, 2'd3, 1, 0);
    push(32'hA2, 0, 1, 2'd2, 1, 0);
    pop(1);
    pop(1);
    pop(1);
    chk("pkt_count_a", u_if.pkt_count, 1);
    chk("rdempty_a", u_if.rdempty, 1);

    // fill to full, hold a 17th word across one pop
    push(32'h100, 1, 0, 2'd0, 1, 0);
    for (int i = 1; i < 16; i++) push(32'h100 + i, 0, 0, 2'd0, 1, 0);
    chk("full_in_ready", u_if.in_ready, 0);
    u_if.in_data  = 32'h110;
    u_if.in_sop   = 1'b0;
    u_if.in_eop   = 1'b1;
    u_if.in_empty = 2'd1;
    u_if.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("held_blocked", u_if.in_ready, 0);
    pop(1);
    chk("ready_after_pop", u_if.in_ready, 1);
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    sb.push_back({32'h110, 1'b0, 1'b1, 2'd1, 1'b0});
    chk("full_again", u_if.in_ready, 0);
    for (int i = 0; i < 16; i++) pop(1);
    chk("data_17_last", u_if.data_out, 32'h110);
    chk("pkt_count_full", u_if.pkt_count, 2);

    // drops while idle
    for (int i = 0; i < 5; i++) push(32'h200 + i, 0, i == 2, 2'd0, 0, 0);
    push(32'hDEADBEEF, 1, 1, 2'd0, 1, 0);
    chk("drop_count", u_if.drop_count, 5);
    pop(1);
    chk("rdempty_drop", u_if.rdempty, 1);

    // missing eop
    push(32'hB0, 1, 0, 2'd0, 1, 0);
    push(32'hB1, 0, 0, 2'd0, 1, 0);
    push(32'hB2, 1, 0, 2'd0, 1, 1);
    push(32'hB3, 0, 1, 2'd3, 1, 0);
    for (int i = 0; i < 4; i++) pop(1);
    chk("pkt_count_b", u_if.pkt_count, 4);

    // pop while empty
    held = u_if.data_out;
    for (int i = 0; i < 4; i++) pop(0);
    chk("empty_hold_data", u_if.data_out, held);
    chk("empty_rdempty", u_if.rdempty, 1);

    // overlapping push/pop at count 1
    push(32'hC0, 1, 0, 2'd0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      u_if.in_data  = 32'hC0 + i;
      u_if.in_sop   = 1'b0;
      u_if.in_eop   = (i == 8);
      u_if.in_empty = 2'd0;
      u_if.in_valid = 1'b1;
      u_if.rdreq    = 1'b1;
      sb.push_back({32'hC0 + i, 1'b0, i == 8, 2'd0, 1'b0});
      @(posedge clk);
      #1;
      chk("ovl_nonempty", u_if.rdempty, 0);
    end
    u_if.in_valid = 1'b0;
    u_if.rdreq    = 1'b0;
    pop(1);
    chk("ovl_drained", u_if.rdempty, 1);
    chk("pkt_count_c", u_if.pkt_count, 5);

    // mid-packet reset
    push(32'hD0, 1, 0, 2'd0, 0, 0);
    for (int i = 1; i < 6; i++) push(32'hD0 + i, 0, 0, 2'd0, 0, 0);
    chk("pre_rst_full6", u_if.rdempty, 0);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    chk("mid_rst_rdempty", u_if.rdempty, 1);
    chk("mid_rst_ready", u_if.in_ready, 1);
    chk("mid_rst_counts", {u_if.drop_count, u_if.pkt_count}, 0);
    push(32'hE0, 0, 0, 2'd0, 0, 0);
    chk("post_rst_drop", u_if.drop_count, 1);
    chk("post_rst_empty", u_if.rdempty, 1);
    pop(0);

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
